wired_cdb_arbiter: RTL
======================

Name: wired_cdb_arbiter

Overview:
- Shares the two CDB broadcast ports among the execution-unit result sources: ALU0, ALU1, the LSU commit FIFO and the MDU.
- Each cycle it grants up to two sources, chosen by fixed priority (index 0 highest), with optional anti-starvation promotion.
- It enforces that the two granted results write different ROB banks.
- Granted results are registered and broadcast one cycle later to the ROB, the issue queues and the dispatch forwarding network.

Parameters:
- N_SRC, 4: number of result sources; index 0 is highest priority (0 = ALU0, 1 = ALU1, 2 = LSU, 3 = MDU).
- ROB_BANK_BITS, 1: low bits of wid that select the ROB bank; two results with equal wid[ROB_BANK_BITS-1:0] conflict.
- STARVE_LIMIT, 3: number of consecutive denied cycles after which a source is promoted (only with the optional feature).

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- flush_i, input, 1: backend flush; drops everything in flight.
- src_valid_i, input, N_SRC: source i has a result.
- src_cdb_i, input, N_SRC x $bits(pipeline_cdb_t): source payloads; the .valid field is ignored.
- src_ready_o, output, N_SRC: grant; a transfer happens when valid & ready.
- cdb_o, output, 2 x $bits(pipeline_cdb_t): registered broadcast; .valid marks a live port.
- conflict_stall_o, output, 1: registered flag; set when a valid source lost port 1 only because of a bank conflict.

Behaviour:
- Reset (rst=1 at a clk edge):
  - cdb_o[0].valid = cdb_o[1].valid = 0; the other cdb_o fields are don't-care.
  - conflict_stall_o = 0; all starvation counters = 0.
  - src_ready_o is combinational but forced to 0 while rst=1.
- Source rule: once src_valid_i[i] is asserted, it and src_cdb_i[i] stay stable until granted; the arbiter may rely on this.
- Grant logic, purely combinational in the same cycle:
  - Port 0 takes the highest-priority valid source.
  - Port 1 takes the highest-priority remaining valid source whose bank differs from port 0's bank.
  - If there is no such candidate, port 1 is idle.
  - At most one grant per source; at most two grants in total.
  - src_ready_o[i] = 1 only for granted sources.
- Latency: a source granted in cycle t appears on cdb_o in cycle t+1.
  - Port assignment is preserved: the port-0 grant drives cdb_o[0], the port-1 grant drives cdb_o[1].
  - With no grant, the port's valid is 0 in t+1.
- No downstream backpressure: the CDB always accepts. There is no skid buffer and no internal queue.
- Port ordering invariant: cdb_o[1].valid=1 implies cdb_o[0].valid=1, and the two banks differ.
- conflict_stall_o <= 1 when, after the port-0 grant, at least one valid ungranted source existed and all of them matched port 0's bank.
- flush_i=1:
  - src_ready_o = 0 in that cycle.
  - Next cycle both cdb_o valids = 0.
  - All counters cleared.
  - A broadcast already on cdb_o in the flush cycle is not retracted.
- rst takes precedence over flush_i.
- A source that deasserts valid without a grant violates the protocol; the arbiter does not check for it.
- N_SRC=1: port 1 is never used.

Optional Feature:
Macro: WIRED_CDB_ARB_STARVE_GUARD_EN
- Defined:
  - Each source has a counter of width $clog2(STARVE_LIMIT+1).
  - Counter update: +1 when valid and not granted, saturating at STARVE_LIMIT; cleared on grant or when valid=0.
  - A source whose counter equals STARVE_LIMIT is treated as priority above all non-starved sources. Among several starved sources, the lowest index wins.
  - Promotion applies to the port-0 selection. Port 1 then proceeds in normal priority order, still subject to the bank rule.
- Undefined: pure fixed priority; counters and promotion logic are absent.

Test Plan:
- Hold rst=1 for 2 cycles with all sources valid -> src_ready_o=0000 and both cdb_o valids 0; the first grant appears in the first cycle after rst=0.
- All 4 valid with wid 0x10, 0x11, 0x12, 0x13 -> ready=0011; next cycle cdb_o[0].wid=0x10, cdb_o[1].wid=0x11, both valid.
- Bank conflict: src0 wid=0x10, src1 wid=0x12, src2 wid=0x13 -> ready=0101; next cycle cdb_o[1].wid=0x13 and conflict_stall_o=0. Same case with src2 invalid -> ready=0001, cdb_o[1].valid=0, conflict_stall_o=1.
- Starvation with the macro defined, STARVE_LIMIT=3: src0/src1 re-present new results every cycle (wids in opposite banks), src3 held valid -> src3 denied 3 cycles, granted on port 0 in the 4th, with src0 moved to port 1. With the macro undefined -> src3 never granted while src0/src1 stay busy.
- flush_i=1 for 1 cycle with all valid -> ready=0000 in that cycle; next cycle both cdb_o valids 0; after flush, src3 (if its counter was near the limit) has restarted its count from 0.
- Only src2 valid (LSU, wid=0x07) -> ready=0100; next cycle cdb_o[0]={valid=1, wid=0x07}, cdb_o[1].valid=0.

Source files
------------

// File: rtl/wired_cdb_arbiter.sv
// wired_cdb_arbiter
// Shares the two CDB broadcast ports among the result sources (ALU0, ALU1,
// LSU commit FIFO, MDU). Each cycle, fixed priority (index 0 highest) grants
// up to two sources. The two granted results must target different ROB banks.
// The grants are registered and broadcast one cycle later.
//
// Optional feature macro: WIRED_CDB_ARB_STARVE_GUARD_EN
//   When defined, each source gets a starvation counter. A source that has
//   been denied STARVE_LIMIT consecutive cycles is promoted for port 0.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush_i           backend flush: no grants this cycle, nothing broadcast next
//   src_valid_i       per-source result valid
//   src_cdb_i         per-source pipeline_cdb_t payload (.valid ignored)
//   src_ready_o       per-source grant (combinational)
//   cdb_o             registered broadcast, two ports of pipeline_cdb_t
//   conflict_stall_o  registered: a valid source lost port 1 purely to a bank clash

package wired_cdb_pkg;
  typedef struct packed {
    logic        valid;
    logic [7:0]  wid;
    logic [31:0] data;
  } pipeline_cdb_t;
endpackage

`ifdef WIRED_CDB_ARB_STARVE_GUARD_EN
// Per-source starvation counter. It saturates at LIMIT while the source waits.
// It clears on a grant, on an idle source, or on a flush.
module wired_cdb_starve_ctr #(
  parameter int LIMIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic valid,
  input  logic grant,
  output logic starved
);
  localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = LIMIT[W-1:0];

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr || !valid || grant) cnt <= '0;
    else if (cnt != LIM)               cnt <= cnt + 1'b1;
  end

  assign starved = (cnt == LIM);
endmodule
`endif

module wired_cdb_arbiter
  import wired_cdb_pkg::*;
#(
  parameter int N_SRC         = 4,
  parameter int ROB_BANK_BITS = 1,
  parameter int STARVE_LIMIT  = 3
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       flush_i,
  input  logic [N_SRC-1:0]                           src_valid_i,
  input  logic [N_SRC-1:0][$bits(pipeline_cdb_t)-1:0] src_cdb_i,
  output logic [N_SRC-1:0]                           src_ready_o,
  output logic [1:0][$bits(pipeline_cdb_t)-1:0]      cdb_o,
  output logic                                       conflict_stall_o
);

  pipeline_cdb_t            src_s [N_SRC];
  logic [N_SRC-1:0]         act, g0, g1;
  logic                     p0_hit, p1_hit, stall_d;
  logic [ROB_BANK_BITS-1:0] bank0;
  pipeline_cdb_t            pay0, pay1, cdb0_q, cdb1_q;
  logic                     stall_q;

`ifdef WIRED_CDB_ARB_STARVE_GUARD_EN
  logic [N_SRC-1:0] starved;

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_starve
    wired_cdb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_ctr (
      .clk     (clk),
      .rst     (rst),
      .clr     (flush_i),
      .valid   (src_valid_i[gi]),
      .grant   (src_ready_o[gi]),
      .starved (starved[gi])
    );
  end
`endif

  always_comb begin
    for (int i = 0; i < N_SRC; i++) src_s[i] = src_cdb_i[i];
  end

  always_comb begin
    // Reset and flush mask every request, so no grant can leak out.
    act    = (rst || flush_i) ? '0 : src_valid_i;
    g0     = '0;
    g1     = '0;
    p0_hit = 1'b0;
    p1_hit = 1'b0;
    pay0   = src_s[0];
    pay1   = src_s[0];
`ifdef WIRED_CDB_ARB_STARVE_GUARD_EN
    // Starved sources outrank everyone for port 0. Ties go to the lowest index.
    for (int i = 0; i < N_SRC; i++) begin
      if (!p0_hit && act[i] && starved[i]) begin
        p0_hit = 1'b1;
        g0[i]  = 1'b1;
        pay0   = src_s[i];
      end
    end
`endif
    for (int i = 0; i < N_SRC; i++) begin
      if (!p0_hit && act[i]) begin
        p0_hit = 1'b1;
        g0[i]  = 1'b1;
        pay0   = src_s[i];
      end
    end
    bank0 = pay0.wid[ROB_BANK_BITS-1:0];
    // Port 1 follows plain priority, but only among sources in the other bank.
    for (int i = 0; i < N_SRC; i++) begin
      if (!p1_hit && act[i] && !g0[i] &&
          (src_s[i].wid[ROB_BANK_BITS-1:0] != bank0)) begin
        p1_hit = 1'b1;
        g1[i]  = 1'b1;
        pay1   = src_s[i];
      end
    end
    // Leftover requesters exist, yet port 1 stayed idle: every one of them clashed.
    stall_d    = p0_hit && !p1_hit && (|(act & ~g0));
    pay0.valid = p0_hit;
    pay1.valid = p1_hit;
  end

  assign src_ready_o = g0 | g1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb0_q.valid <= 1'b0;
      cdb1_q.valid <= 1'b0;
      stall_q      <= 1'b0;
    end else begin
      cdb0_q  <= pay0;
      cdb1_q  <= pay1;
      stall_q <= stall_d;
    end
  end

  assign cdb_o[0]         = cdb0_q;
  assign cdb_o[1]         = cdb1_q;
  assign conflict_stall_o = stall_q;

endmodule
